// File: rtl/router_pkg.sv
// router_pkg
//   Shared types and helpers for the 1-to-N trusted packet router.
//   - state_t    : input-side FSM states (IDLE, HDR, FWD, DROP)
//   - FIFO entry : {last, data}; the last flag sits one bit above the data byte
//   - is_trusted : matches a source ID against a packed list of trusted IDs
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,  // waiting for byte 0 (dest_id)
    ST_HDR,   // waiting for byte 1 (src_id), trust check pending
    ST_FWD,   // forwarding payload bytes into the selected FIFO
    ST_DROP   // discarding bytes until last
  } state_t;

  // Upper bounds for the trusted-list helper. The list is zero-extended
  // to this size by the caller so that one function body serves any
  // DW/NTS combination within the bounds.
  localparam int MAX_DW    = 32;
  localparam int MAX_NTS   = 16;
  localparam int TS_LIST_W = MAX_DW * MAX_NTS;

  // Returns 1 when id matches any of the first nts entries of list.
  // Entry k occupies bits [k*dw +: dw]; bits of id above dw are ignored.
  function automatic logic is_trusted(input logic [TS_LIST_W-1:0] list,
                                      input int                   nts,
                                      input int                   dw,
                                      input logic [MAX_DW-1:0]    id);
    logic [MAX_DW-1:0]    mask;
    logic [TS_LIST_W-1:0] shifted;
    logic                 hit;
    mask = MAX_DW'((64'd1 << dw) - 64'd1);
    hit  = 1'b0;
    for (int k = 0; k < MAX_NTS; k++) begin
      shifted = list >> (k * dw);
      if ((k < nts) && ((shifted[MAX_DW-1:0] & mask) == (id & mask))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo
//   Synchronous single-clock FIFO used as one output queue of the router.
//   Pointers carry one extra MSB so full and empty are told apart by
//   comparing the wrap bit. Read data is the combinational head entry;
//   the router registers it when it pops.
// Ports
//   clk      in   1      clock, posedge
//   rst      in   1      asynchronous active-high reset (pointers only)
//   wr_en    in   1      push wr_data (ignored when full)
//   wr_data  in   WIDTH  entry to push
//   rd_en    in   1      pop head entry (ignored when empty)
//   rd_data  out  WIDTH  current head entry
//   full     out  1      DEPTH entries stored
//   empty    out  1      no entries stored
module router_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers alone, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/router_1xn_trusted.sv
// router_1xn_trusted
//   Single-clock 1-to-N packet router. Packets arrive byte-wide with a
//   valid/ready/last handshake: byte0 = dest_id, byte1 = src_id, then
//   payload. dest_id selects output port dest_id-1 and is stripped;
//   src_id must be on the trusted list. Accepted packets are queued in a
//   per-port FIFO and drained independently under each port's stop input.
//   Malformed, misaddressed and untrusted packets are counted.
// Ports
//   clk               in   1          clock, posedge
//   rst               in   1          asynchronous active-high reset
//   packet_in         in   DW         input byte
//   packet_valid_i    in   1          packet_in valid
//   packet_last_i     in   1          final byte of packet
//   packet_ready_o    out  1          byte accepted when valid & ready at posedge
//   stop_packet_send  in   NPORTS     bit i high holds port i
//   packet_valid_o    out  NPORTS     port i byte valid (one cycle per byte)
//   packet_last_o     out  NPORTS     port i byte is last of packet
//   packet_out        out  NPORTS*DW  port i byte at [i*DW +: DW]
//   drop_cnt_o        out  CNT_W      saturating dropped-packet count
module router_1xn_trusted
  import router_pkg::*;
#(
  parameter int                NPORTS      = 3,
  parameter int                DW          = 8,
  parameter int                DEPTH       = 16,
  parameter int                NTS         = 3,
  parameter logic [NTS*DW-1:0] TRUSTED_IDS = {8'd30, 8'd20, 8'd10},
  parameter int                CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        packet_in,
  input  logic                 packet_valid_i,
  input  logic                 packet_last_i,
  output logic                 packet_ready_o,
  input  logic [NPORTS-1:0]    stop_packet_send,
  output logic [NPORTS-1:0]    packet_valid_o,
  output logic [NPORTS-1:0]    packet_last_o,
  output logic [NPORTS*DW-1:0] packet_out,
  output logic [CNT_W-1:0]     drop_cnt_o
);

  localparam int                   PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int                   EW       = DW + 1;
  localparam logic [DW-1:0]        NPORTS_D = DW'(NPORTS);
  localparam logic [TS_LIST_W-1:0] TS_LIST  = TS_LIST_W'(TRUSTED_IDS);

  state_t           state;
  logic [PW-1:0]    port_sel;
  logic [CNT_W-1:0] drop_cnt;

  logic [NPORTS-1:0] fifo_full;
  logic [NPORTS-1:0] fifo_empty;
  logic [NPORTS-1:0] fifo_wr;
  logic [NPORTS-1:0] fifo_rd;
  logic [EW-1:0]     fifo_rd_data [NPORTS];

  logic ready_int;
  logic accept;
  logic dest_ok;
  logic src_ok;
  logic sel_full;
  logic fwd_write;
  logic drop_inc;

  // Byte decode; only meaningful in the state that consumes the byte.
  assign dest_ok  = (packet_in != '0) && (packet_in <= NPORTS_D);
  assign src_ok   = is_trusted(TS_LIST, NTS, DW, MAX_DW'(packet_in));
  assign sel_full = fifo_full[port_sel];

  // NOTE: every signal assigned in always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ready_int = 1'b1;
    case (state)
      ST_HDR, ST_FWD: ready_int = !sel_full;
      default:        ready_int = 1'b1;
    endcase
  end

  // Ready is forced low for the whole time reset is held.
  assign packet_ready_o = ready_int & ~rst;
  assign accept         = packet_valid_i & packet_ready_o;

  // A trusted header byte (src_id) and every forwarded byte go to the FIFO.
  assign fwd_write = accept && (((state == ST_HDR) && src_ok) || (state == ST_FWD));

  // One increment per dropped packet: a 1-byte packet or bad dest in IDLE,
  // or an untrusted source in HDR.
  assign drop_inc = accept &&
                    (((state == ST_IDLE) && (packet_last_i || !dest_ok)) ||
                     ((state == ST_HDR) && !src_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      port_sel <= '0;
      drop_cnt <= '0;
    end else begin
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            port_sel <= PW'(packet_in - 1'b1);
            if (packet_last_i) state <= ST_IDLE;
            else if (!dest_ok) state <= ST_DROP;
            else               state <= ST_HDR;
          end
          ST_HDR: begin
            if (packet_last_i) state <= ST_IDLE;
            else if (src_ok)   state <= ST_FWD;
            else               state <= ST_DROP;
          end
          ST_FWD:  if (packet_last_i) state <= ST_IDLE;
          ST_DROP: if (packet_last_i) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign drop_cnt_o = drop_cnt;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign fifo_wr[i] = fwd_write && (port_sel == PW'(i));
    assign fifo_rd[i] = !fifo_empty[i] && !stop_packet_send[i];

    router_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr[i]),
      .wr_data ({packet_last_i, packet_in}),
      .rd_en   (fifo_rd[i]),
      .rd_data (fifo_rd_data[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  // Output registers: a pop presents its entry for exactly one cycle;
  // data and last hold their previous value while the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_valid_o <= '0;
      packet_last_o  <= '0;
      packet_out     <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        packet_valid_o[i] <= fifo_rd[i];
        if (fifo_rd[i]) begin
          packet_last_o[i]         <= fifo_rd_data[i][DW];
          packet_out[i*DW +: DW]   <= fifo_rd_data[i][DW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_router_1xn_trusted.sv
// Self-checking bench for router_1xn_trusted. A packet-level reference
// model classifies each packet (malformed / bad dest / untrusted / good)
// and queues the expected {last, byte} stream per port; a negedge monitor
// compares every output beat against those queues.
module tb_router_1xn_trusted;

  localparam int NP    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      packet_in;
  logic               packet_valid_i;
  logic               packet_last_i;
  logic               packet_ready_o;
  logic [NP-1:0]      stop_packet_send;
  logic [NP-1:0]      packet_valid_o;
  logic [NP-1:0]      packet_last_o;
  logic [NP*DW-1:0]   packet_out;
  logic [CNT_W-1:0]   drop_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [8:0]    exp_q [NP][$];
  int            exp_drop;
  logic [7:0]    pkt [$];
  logic [NP-1:0] rand_stop_mask = '0;
  logic [7:0]    trusted [3] = '{8'd10, 8'd20, 8'd30};

  always #5 clk = ~clk;

  router_1xn_trusted #(
    .NPORTS      (NP),
    .DW          (DW),
    .DEPTH       (DEPTH),
    .NTS         (3),
    .TRUSTED_IDS ({8'd30, 8'd20, 8'd10}),
    .CNT_W       (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .packet_in        (packet_in),
    .packet_valid_i   (packet_valid_i),
    .packet_last_i    (packet_last_i),
    .packet_ready_o   (packet_ready_o),
    .stop_packet_send (stop_packet_send),
    .packet_valid_o   (packet_valid_o),
    .packet_last_o    (packet_last_o),
    .packet_out       (packet_out),
    .drop_cnt_o       (drop_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: every valid beat must match the head of its port queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst === 1'b0) begin
      for (int i = 0; i < NP; i++) begin
        if (packet_valid_o[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("port%0d_unexpected_valid", i), 32'(packet_valid_o[i]), 32'd0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("port%0d_data", i), 32'(packet_out[i*DW +: DW]), 32'(e[7:0]));
            check($sformatf("port%0d_last", i), 32'(packet_last_o[i]), 32'(e[8]));
          end
        end
      end
    end
  end

  // Random backpressure on the ports selected by rand_stop_mask.
  always @(negedge clk) begin
    if (rand_stop_mask != '0) stop_packet_send = NP'($urandom) & rand_stop_mask;
  end

  // Reference model: classify the packet held in pkt and queue its output.
  task automatic model_pkt();
    int         n;
    logic [7:0] d;
    logic [7:0] s;
    bit         ok;
    n = pkt.size();
    if (n < 2) begin exp_drop++; return; end
    d = pkt[0];
    s = pkt[1];
    if (d < 1 || d > NP) begin exp_drop++; return; end
    ok = 0;
    foreach (trusted[k]) if (s == trusted[k]) ok = 1;
    if (!ok) begin exp_drop++; return; end
    for (int j = 1; j < n; j++) exp_q[d-1].push_back({(j == n - 1), pkt[j]});
  endtask

  // Present one byte at a negedge and hold it until accepted at a posedge.
  task automatic drive_byte(input logic [7:0] b, input logic last, output int waits);
    packet_in      = b;
    packet_last_i  = last;
    packet_valid_i = 1'b1;
    waits = 0;
    while (packet_ready_o !== 1'b1 && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    if (packet_ready_o !== 1'b1) check("ready_timeout", 32'(packet_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    packet_valid_i = 1'b0;
    packet_last_i  = 1'b0;
  endtask

  task automatic send_pkt(output int max_waits);
    int w;
    max_waits = 0;
    model_pkt();
    for (int j = 0; j < pkt.size(); j++) begin
      drive_byte(pkt[j], (j == pkt.size() - 1), w);
      if (w > max_waits) max_waits = w;
    end
    check("drop_cnt", 32'(drop_cnt_o), 32'(exp_drop));
  endtask

  task automatic drain();
    int cyc = 0;
    rand_stop_mask   = '0;
    stop_packet_send = '0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_remaining", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int len;
    int d;
    rst              = 1'b1;
    packet_in        = '0;
    packet_valid_i   = 1'b0;
    packet_last_i    = 1'b0;
    stop_packet_send = '0;
    exp_drop         = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid_o", 32'(packet_valid_o), 32'd0);
    check("rst_last_o",  32'(packet_last_o),  32'd0);
    check("rst_out",     32'(packet_out),     32'd0);
    check("rst_drop",    32'(drop_cnt_o),     32'd0);
    check("rst_ready",   32'(packet_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(packet_ready_o), 32'd1);

    // 1: basic forward to port 1
    pkt = '{8'd2, 8'd20, 8'hA5, 8'h5A};
    send_pkt(w);
    drain();

    // 2: bad destinations are dropped without backpressure
    pkt = '{8'd0, 8'd20, 8'd1, 8'd2};
    send_pkt(w);
    check("baddest0_waits", 32'(w), 32'd0);
    pkt = '{8'd4, 8'd20, 8'd3, 8'd4};
    send_pkt(w);
    check("baddest4_waits", 32'(w), 32'd0);
    check("drop_after_baddest", 32'(drop_cnt_o), 32'd2);
    drain();
    check("ready_after_drops", 32'(packet_ready_o), 32'd1);

    // 3: untrusted source then trusted source to port 0
    pkt = '{8'd1, 8'd99, 8'd11, 8'd22, 8'd33};
    send_pkt(w);
    pkt = '{8'd1, 8'd30, 8'd44, 8'd55};
    send_pkt(w);
    drain();

    // 4: fill port 0 FIFO under stop, then release
    stop_packet_send = 3'b001;
    pkt.delete();
    pkt.push_back(8'd1);
    pkt.push_back(8'd10);
    for (int j = 0; j < 18; j++) pkt.push_back(8'(8'h40 + j));
    model_pkt();
    for (int j = 0; j < 17; j++) begin
      drive_byte(pkt[j], 1'b0, w);
      check("fill_waits", 32'(w), 32'd0);
    end
    check("ready_low_when_full", 32'(packet_ready_o), 32'd0);
    repeat (4) @(negedge clk);
    check("ready_stays_low", 32'(packet_ready_o), 32'd0);
    check("port0_held_by_stop", 32'(packet_valid_o[0]), 32'd0);
    stop_packet_send = 3'b000;
    @(negedge clk);
    check("ready_reasserts", 32'(packet_ready_o), 32'd1);
    for (int j = 17; j < 20; j++) drive_byte(pkt[j], (j == 19), w);
    check("drop_after_fill", 32'(drop_cnt_o), 32'(exp_drop));
    drain();

    // 5: interleave ports 0 and 2 with stop toggling on port 0
    rand_stop_mask = 3'b001;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(2, 10);
      pkt.delete();
      pkt.push_back((p % 2 == 0) ? 8'd1 : 8'd3);
      pkt.push_back(trusted[$urandom_range(0, 2)]);
      for (int j = 2; j < len; j++) pkt.push_back(8'($urandom));
      send_pkt(w);
    end
    drain();

    // Randomized traffic on all ports with random backpressure
    rand_stop_mask = 3'b111;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      d   = $urandom_range(0, 4);
      pkt.delete();
      pkt.push_back(8'(d));
      if (len > 1) pkt.push_back(($urandom_range(0, 3) != 0) ? trusted[$urandom_range(0, 2)]
                                                            : 8'($urandom_range(31, 255)));
      for (int j = 2; j < len; j++) pkt.push_back(8'($urandom));
      send_pkt(w);
    end
    drain();

    // 6: reset mid-FWD with data buffered in port 2
    stop_packet_send = 3'b100;
    pkt = '{8'd3, 8'd20, 8'hC1, 8'hC2, 8'hC3};
    for (int j = 0; j < 5; j++) drive_byte(pkt[j], 1'b0, w);
    rst = 1'b1;
    #1;
    check("midrst_valid_o", 32'(packet_valid_o), 32'd0);
    check("midrst_last_o",  32'(packet_last_o),  32'd0);
    check("midrst_out",     32'(packet_out),     32'd0);
    check("midrst_ready",   32'(packet_ready_o), 32'd0);
    check("midrst_drop",    32'(drop_cnt_o),     32'd0);
    for (int i = 0; i < NP; i++) exp_q[i].delete();
    exp_drop = 0;
    @(negedge clk);
    rst              = 1'b0;
    stop_packet_send = 3'b000;
    repeat (20) @(negedge clk);
    check("postrst_no_output", 32'(packet_valid_o), 32'd0);
    pkt = '{8'd2};
    send_pkt(w);
    check("one_byte_drop", 32'(drop_cnt_o), 32'd1);
    pkt = '{8'd3, 8'd10, 8'h77};
    send_pkt(w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
